// File: rtl/trend_detector.sv
// trend_detector: classifies a signed temperature derivative stream as
// STABLE / RISING / FALLING. Entry uses th_up, and release uses the smaller
// of th_dn and th_up. Every transition needs a run of consecutive
// qualifying samples.
// Optional feature macro: TREND_DETECTOR_PEAK_EN (peak |dT_in| tracking).
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | after reset/init; waiting for the first valid sample
// S_STABLE  | derivative within thresholds
// S_RISING  | sustained positive derivative at or above th_up
// S_FALLING | sustained negative derivative at or below -th_up
module trend_detector (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [7:0] dT_in,
  input  logic              dt_valid,
  input  logic              init,
  input  logic [7:0]        th_up,
  input  logic [7:0]        th_dn,
  input  logic [7:0]        persist,
  output logic [1:0]        trend,
  output logic              trend_change,
  output logic              trend_valid,
  output logic [7:0]        dT_peak
);

  typedef enum logic [1:0] {S_IDLE, S_STABLE, S_RISING, S_FALLING} state_t;
  typedef enum logic [1:0] {C_NONE, C_RISE, C_FALL, C_STAB} cand_t;

  state_t state_q, state_d;
  cand_t  cand_q, cand_d, cand_now;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic       fire;

  // 9-bit signed compare operands, so thresholds 128..255 stay meaningful
  logic signed [8:0] d9, up9, nup9, rel9, nrel9;
  logic [7:0]        rel8, pe8;

  assign d9    = {dT_in[7], dT_in};
  assign up9   = {1'b0, th_up};
  assign nup9  = -up9;
  assign rel8  = (th_dn < th_up) ? th_dn : th_up;
  assign rel9  = {1'b0, rel8};
  assign nrel9 = -rel9;
  assign pe8   = (persist == 8'd0) ? 8'd1 : persist;

  function automatic state_t cand_to_state(input cand_t c);
    case (c)
      C_RISE:  cand_to_state = S_RISING;
      C_FALL:  cand_to_state = S_FALLING;
      default: cand_to_state = S_STABLE;
    endcase
  endfunction

  function automatic logic [1:0] enc_trend(input state_t s);
    case (s)
      S_RISING:  enc_trend = 2'b01;
      S_FALLING: enc_trend = 2'b10;
      default:   enc_trend = 2'b00;
    endcase
  endfunction

  // candidate transition implied by the current sample in the current state
  always_comb begin
    cand_now = C_NONE;
    case (state_q)
      S_STABLE: begin
        if (d9 >= up9)       cand_now = C_RISE;
        else if (d9 <= nup9) cand_now = C_FALL;
      end
      S_RISING: begin
        if (d9 <= nup9)      cand_now = C_FALL;
        else if (d9 < rel9)  cand_now = C_STAB;
      end
      S_FALLING: begin
        if (d9 >= up9)       cand_now = C_RISE;
        else if (d9 > nrel9) cand_now = C_STAB;
      end
      default: cand_now = C_NONE;
    endcase
  end

  // next state, persistence counter and candidate register
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    // cand_q is never C_NONE when it matters, so a NONE sample cannot match it
    if (cand_now == cand_q)
      cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    else
      cnt_inc = 8'd1;

    if (init) begin
      state_d = S_IDLE;
      cand_d  = C_NONE;
      cnt_d   = 8'd0;
    end else if (dt_valid) begin
      if (state_q == S_IDLE) begin
        state_d = S_STABLE;
      end else if (cand_now == C_NONE) begin
        cnt_d = 8'd0;
      end else if (cnt_inc >= pe8) begin
        // >= so that lowering persist mid-run fires on the next matching sample
        fire    = 1'b1;
        state_d = cand_to_state(cand_now);
        cand_d  = C_NONE;
        cnt_d   = 8'd0;
      end else begin
        cand_d = cand_now;
        cnt_d  = cnt_inc;
      end
    end
  end

  // state, counter and candidate registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cand_q  <= C_NONE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      trend        <= 2'b00;
      trend_change <= 1'b0;
      trend_valid  <= 1'b0;
    end else begin
      trend        <= enc_trend(state_d);
      trend_change <= fire;
      trend_valid  <= (state_d != S_IDLE);
    end
  end

`ifdef TREND_DETECTOR_PEAK_EN
  logic [7:0] raw_d, abs_d;

  assign raw_d = dT_in;
  // |-128| does not fit in Q7.0, so it saturates to 127
  assign abs_d = raw_d[7] ? ((raw_d == 8'h80) ? 8'h7F : (~raw_d + 8'd1)) : raw_d;

  // peak |dT_in| since the last trend change, reloaded on the transition sample
  always_ff @(posedge clk) begin
    if (rst || init) begin
      dT_peak <= 8'd0;
    end else if (dt_valid && state_q != S_IDLE) begin
      if (fire)                dT_peak <= abs_d;
      else if (abs_d > dT_peak) dT_peak <= abs_d;
    end
  end
`else
  assign dT_peak = 8'd0;
`endif

endmodule

// File: tb/tb_trend_detector.sv
// Directed bench for trend_detector: each step drives one cycle of stimulus,
// pushes the hand-derived expected outputs to a scoreboard queue and pops and
// compares them after the clock edge that produces them.
module tb_trend_detector;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [7:0] dT_in = '0;
  logic              dt_valid = 1'b0;
  logic              init = 1'b0;
  logic [7:0]        th_up = 8'd5;
  logic [7:0]        th_dn = 8'd2;
  logic [7:0]        persist = 8'd3;
  logic [1:0]        trend;
  logic              trend_change;
  logic              trend_valid;
  logic [7:0]        dT_peak;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [1:0] tr;
    logic       ch;
    logic       vl;
    logic       chk_pk;
    logic [7:0] pk;
  } exp_t;

  exp_t sb[$];

  trend_detector dut (
    .clk(clk), .rst(rst), .dT_in(dT_in), .dt_valid(dt_valid), .init(init),
    .th_up(th_up), .th_dn(th_dn), .persist(persist),
    .trend(trend), .trend_change(trend_change), .trend_valid(trend_valid),
    .dT_peak(dT_peak)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic step(input logic v, input int d, input logic i,
                      input logic [1:0] tr, input logic ch, input logic vl,
                      input logic cp, input logic [7:0] pk, input string tag);
    exp_t e;
    logic [7:0] pk_exp;
    logic       pk_chk;
    dt_valid = v;
    dT_in    = 8'(d);
    init     = i;
    e.tag = tag; e.tr = tr; e.ch = ch; e.vl = vl; e.chk_pk = cp; e.pk = pk;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue want entry", tag);
      return;
    end
    e = sb.pop_front();
`ifdef TREND_DETECTOR_PEAK_EN
    pk_exp = e.pk;
    pk_chk = e.chk_pk;
`else
    pk_exp = 8'd0;
    pk_chk = 1'b1;
`endif
    checks++;
    assert (trend === e.tr) else begin
      errors++;
      $error("FAIL %s trend: got %b want %b", e.tag, trend, e.tr);
    end
    checks++;
    assert (trend_change === e.ch) else begin
      errors++;
      $error("FAIL %s trend_change: got %b want %b", e.tag, trend_change, e.ch);
    end
    checks++;
    assert (trend_valid === e.vl) else begin
      errors++;
      $error("FAIL %s trend_valid: got %b want %b", e.tag, trend_valid, e.vl);
    end
    if (pk_chk) begin
      checks++;
      assert (dT_peak === pk_exp) else begin
        errors++;
        $error("FAIL %s dT_peak: got %0d want %0d", e.tag, dT_peak, pk_exp);
      end
    end
  endtask

  initial begin
    // reset and first sample
    rst = 1'b1;
    step(0, 0, 0, 2'b00, 0, 0, 1, 8'd0, "reset");
    rst = 1'b0;
    th_up = 8'd5; th_dn = 8'd2; persist = 8'd3;
    step(0, 0, 0, 2'b00, 0, 0, 1, 8'd0, "idle_hold");
    step(1, 0, 0, 2'b00, 0, 1, 0, 8'd0, "first_sample");

    // STABLE -> RISING after three qualifying samples
    step(1, 6, 0, 2'b00, 0, 1, 0, 8'd0, "rise1");
    step(1, 6, 0, 2'b00, 0, 1, 0, 8'd0, "rise2");
    step(1, 6, 0, 2'b01, 1, 1, 1, 8'd6, "rise3");
    step(0, 0, 0, 2'b01, 0, 1, 0, 8'd0, "rise_pulse_once");

    // RISING: 3 is in the hysteresis band, 1 releases
    step(1, 3, 0, 2'b01, 0, 1, 0, 8'd0, "band1");
    step(1, 3, 0, 2'b01, 0, 1, 1, 8'd6, "band2");
    step(1, 1, 0, 2'b01, 0, 1, 0, 8'd0, "rel1");
    step(1, 1, 0, 2'b01, 0, 1, 0, 8'd0, "rel2");
    step(1, 1, 0, 2'b00, 1, 1, 1, 8'd1, "rel3");

    // interrupted run: a non-qualifying sample restarts the count
    step(1, 6, 0, 2'b00, 0, 1, 0, 8'd0, "int_a1");
    step(1, 6, 0, 2'b00, 0, 1, 0, 8'd0, "int_a2");
    step(1, 0, 0, 2'b00, 0, 1, 0, 8'd0, "int_a_break");
    step(1, 6, 0, 2'b00, 0, 1, 0, 8'd0, "int_a3");
    step(1, 6, 0, 2'b00, 0, 1, 0, 8'd0, "int_a4");
    step(1, 0, 0, 2'b00, 0, 1, 0, 8'd0, "int_a_clear");

    // gaps in dt_valid do not break a run
    step(1, 6, 0, 2'b00, 0, 1, 0, 8'd0, "gap_s1");
    step(1, 6, 0, 2'b00, 0, 1, 0, 8'd0, "gap_s2");
    for (int k = 0; k < 4; k++)
      step(0, 6, 0, 2'b00, 0, 1, 0, 8'd0, "gap_hold");
    step(1, 6, 0, 2'b01, 1, 1, 0, 8'd0, "gap_s3");

    // back to STABLE
    step(1, 1, 0, 2'b01, 0, 1, 0, 8'd0, "back1");
    step(1, 1, 0, 2'b01, 0, 1, 0, 8'd0, "back2");
    step(1, 1, 0, 2'b00, 1, 1, 1, 8'd1, "back3");

    // wide thresholds: -128 never reaches -200; peak saturates at 127
    th_up = 8'd200;
    step(1, -128, 0, 2'b00, 0, 1, 1, 8'd127, "th200_a");
    step(1, -128, 0, 2'b00, 0, 1, 0, 8'd0, "th200_b");
    step(1, -128, 0, 2'b00, 0, 1, 0, 8'd0, "th200_c");

    // th_up=128, persist=0 -> one sample of -128 is enough
    th_up = 8'd128; persist = 8'd0;
    step(1, -128, 0, 2'b10, 1, 1, 1, 8'd127, "th128_fall");
    step(1, -1, 0, 2'b00, 1, 1, 1, 8'd1, "fall_release");

    // raising persist then lowering below the current count
    th_up = 8'd5; persist = 8'd5;
    step(1, 6, 0, 2'b00, 0, 1, 0, 8'd0, "pchg1");
    step(1, 6, 0, 2'b00, 0, 1, 0, 8'd0, "pchg2");
    step(1, 6, 0, 2'b00, 0, 1, 0, 8'd0, "pchg3");
    persist = 8'd2;
    step(1, 6, 0, 2'b01, 1, 1, 0, 8'd0, "pchg_fire");

    // init during a run discards the simultaneous sample
    persist = 8'd3;
    step(1, -6, 0, 2'b01, 0, 1, 0, 8'd0, "run_fall1");
    step(1, -6, 1, 2'b00, 0, 0, 1, 8'd0, "init");
    step(1, -6, 0, 2'b00, 0, 1, 0, 8'd0, "post_init_first");
    step(1, -6, 0, 2'b00, 0, 1, 0, 8'd0, "post_init_f1");
    step(1, -6, 0, 2'b00, 0, 1, 0, 8'd0, "post_init_f2");
    step(1, -6, 0, 2'b10, 1, 1, 1, 8'd6, "post_init_f3");

    // release threshold is min(th_dn, th_up)
    persist = 8'd1; th_dn = 8'd50;
    step(1, -10, 0, 2'b10, 0, 1, 0, 8'd0, "rel_min_none");
    step(1, -3, 0, 2'b00, 1, 1, 1, 8'd3, "rel_min_stab");
    th_dn = 8'd2;

    // reset mid-run overrides dt_valid and clears the counter
    persist = 8'd3;
    step(1, 6, 0, 2'b00, 0, 1, 0, 8'd0, "pre_rst");
    rst = 1'b1;
    step(1, 6, 0, 2'b00, 0, 0, 1, 8'd0, "mid_reset");
    rst = 1'b0;
    step(1, 0, 0, 2'b00, 0, 1, 0, 8'd0, "rst_first");
    step(1, 6, 0, 2'b00, 0, 1, 0, 8'd0, "rst_r1");
    step(1, 6, 0, 2'b00, 0, 1, 0, 8'd0, "rst_r2");
    step(1, 6, 0, 2'b01, 1, 1, 0, 8'd0, "rst_r3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trend_detector.md
TREND_DETECTOR -- requirements
Module: trend_detector

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 rst  input  1  synchronous reset, active-high.
REQ-003 dT_in  input  8 signed  temperature derivative, Q7.0, from the dT estimator output.
REQ-004 dt_valid  input  1  dT_in qualifier; one sample per high cycle.
REQ-005 init  input  1  one-cycle restart pulse, shared with the dT estimator.
REQ-006 th_up  input  8 unsigned  entry threshold, Q7.0 magnitude.
REQ-007 th_dn  input  8 unsigned  release threshold, Q7.0 magnitude.
REQ-008 persist  input  8 unsigned  consecutive qualifying samples required per transition.
REQ-009 trend  output  2  00 STABLE, 01 RISING, 10 FALLING, 11 never driven.
REQ-010 trend_change  output  1  one-cycle pulse when trend changes.
REQ-011 trend_valid  output  1  high once the first valid sample after reset/init is consumed.
REQ-012 dT_peak  output  8 unsigned  peak |dT_in| since last trend change (see Configuration).

Function
REQ-013 FSM states: IDLE, STABLE, RISING, FALLING; IDLE encodes trend=00 with trend_valid=0.
REQ-014 Comparisons SHALL be 9-bit signed: dT_in sign-extended, thresholds zero-extended, negations in 9 bits, so thresholds 128..255 are legal.
REQ-015 Effective release threshold rel = min(th_dn, th_up); effective persistence pe = max(persist, 1).
REQ-016 IDLE: first cycle with dt_valid=1 -> STABLE, trend_valid=1 next cycle; sample is not counted.
REQ-017 Candidate per valid sample:
  - STABLE: dT_in >= th_up -> RISE; dT_in <= -th_up -> FALL; else NONE.
  - RISING: dT_in <= -th_up -> FALL; dT_in < rel -> STAB; else NONE.
  - FALLING: dT_in >= th_up -> RISE; dT_in > -rel -> STAB; else NONE.
REQ-018 Persistence counter (8-bit, saturating at 255) and cand register:
  - NONE clears the counter.
  - A candidate equal to cand increments the counter.
  - A different candidate loads cand and sets the counter to 1.
REQ-019 When the post-update count reaches pe:
  - state moves to the candidate's state;
  - counter clears and cand clears;
  - trend updates and trend_change=1 on the following cycle (1-cycle latency from the qualifying sample).
REQ-020 dt_valid=0 SHALL hold state, counter, cand and outputs; a gap does not break a run.
REQ-021 init=1 SHALL return to IDLE, clear counter/cand/dT_peak, and set trend=00, trend_change=0, trend_valid=0 next cycle.
REQ-022 init has priority over a simultaneous dt_valid; that sample is discarded.
REQ-023 persist changes mid-run take effect at the next compare; if the current count already exceeds the new pe, the next matching sample transitions.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 On rst=1 at a clk edge, all state SHALL clear as for init (IDLE, trend=00, trend_change=0, trend_valid=0, dT_peak=0).
REQ-026 Reset mid-run SHALL take effect regardless of dt_valid/init, and SHALL be held for at least 1 cycle.

Configuration
REQ-027 Macro TREND_DETECTOR_PEAK_EN.
REQ-028 Defined:
  - dT_peak tracks max |dT_in| over valid samples in STABLE/RISING/FALLING, with |-128| saturating to 127;
  - dT_peak reloads with the current |dT_in| on the transition cycle.
REQ-029 Undefined: the port remains, is tied to 0, and no peak logic is synthesized.

Verification
REQ-030 Reset, then one valid sample dT=0 -> trend_valid=1, trend=00 next cycle, no trend_change.
REQ-031 th_up=5, th_dn=2, persist=3, dT=6 x3 valid -> trend=01 and a single trend_change one cycle after the 3rd sample.
REQ-032 From RISING with the same config: dT=3,3,1,1,1 -> stays 01 through the 3s, -> 00 after the third 1.
REQ-033 Interrupted runs (persist=3, STABLE):
  - dT=6,6,0,6,6 -> no transition;
  - dT=6,6,(dt_valid=0 x4),6 -> RISING.
REQ-034 STABLE, th_up=200, dT=-128 x persist -> remains STABLE; th_up=128, dT=-128 x1, persist=0 -> FALLING.
REQ-035 init during a RISING run with dt_valid=1 -> IDLE, trend_valid=0, sample ignored; with PEAK_EN, dT_peak=0; after dT=-128 in STABLE, dT_peak=127.
